id_stage_hs: RTL and testbench
==============================

Name: id_stage_hs

Overview:
Parametrised instruction-decode stage with valid/ready handshakes on both sides.
- Holds one fetched instruction in an ID holding register and decodes it.
- Reads the register file it contains, with optional WB-to-ID bypass.
- Detects load-use hazards and resolves jumps and branches.
- Drives a registered ID/EX output with backpressure.
Sits between the fetch unit and the execute stage. It replaces the free-running, clk_en-only ID/EX register with a stallable, bubble-inserting stage.

Parameters:
XLEN, 32, datapath width; only 32 is legal.
NUM_REGS, 32, architectural register count; 32 for RV32I, 16 for RV32E.
BYPASS_WB, 1, 1 = forward the same-cycle WB write to the rs1/rs2 read data.

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
clk_en  in  1  global enable; when 0, all state holds
if_valid  in  1  fetch beat valid
if_ready  out  1  ID can accept a beat
if_inst  in  32  instruction
if_pc  in  XLEN  PC of the instruction
wb_wr_en  in  1  register write enable
wb_rd_addr  in  $clog2(NUM_REGS)  write address
wb_data  in  XLEN  write data
flush  in  1  kill ID and EX contents
ex_valid  out  1  ID/EX entry valid
ex_ready  in  1  execute accepts the entry
ex_ctrl  out  idCtrl_t  decoded control
ex_pc, ex_rs1, ex_rs2, ex_imm  out  XLEN  operands
ex_rd_addr, ex_rs1_addr, ex_rs2_addr  out  $clog2(NUM_REGS)  register addresses
ex_funct3  out  3  load/store size
branch_taken  out  1  redirect fetch
jump_addr  out  XLEN  redirect target
hazard_stall  out  1  load-use stall is active this cycle

Behaviour:
Reset and enable:
- Reset is synchronous and active-low, and has priority over clk_en and flush.
- While rst_n=0: ex_valid=0, ex_ctrl=ID_NOP, all ex_* data/addresses=0, internal id_valid=0, register file all zero. if_ready=0, branch_taken=0 and hazard_stall=0 combinationally.
- clk_en=0: no state change. if_ready, branch_taken and hazard_stall are forced 0.

Definitions:
- load_use = id_valid & ex_valid & ex_ctrl.data_rd_en & ex_rd_addr!=0 & ((uses_rs1 & ex_rd_addr==rs1) | (uses_rs2 & ex_rd_addr==rs2)).
- ex_free = !ex_valid | ex_ready.
- id_fire = id_valid & ex_free & !load_use & !flush.
- if_ready = (!id_valid | id_fire) & !branch_taken & !flush.

Pipeline and handshake:
- Latency: if_valid&if_ready at edge N; entry appears on ex_* after edge N+1 if there is no stall.
- On id_fire: ex_* is loaded from the decode and ex_valid=1.
- Else if ex_ready & ex_valid: ex_valid=0, so a bubble is inserted.
- Else: ex_* holds bit-stable.
- hazard_stall = load_use & ex_free. A load-use stall inserts exactly one bubble.

Register file:
- NUM_REGS x XLEN; x0 reads 0 and writes to it are ignored.
- A write lands at the edge.
- With BYPASS_WB=1, a read of an address matching an active WB write (address !=0) returns wb_data in the same cycle.

Decode and immediates:
- Decode is RV32I; immediates follow the ISA I/S/B/U/J formats, sign-extended.
- An unknown opcode, or a register address >= NUM_REGS, sets ex_ctrl.illegal=1. The entry then carries ID_NOP control with rd_wr_en=0; it still flows through the pipe.

Jump and branch:
- branch_taken = id_fire & (uncond_jump | (cond_jump & condition true)). Conditions: BEQ/BNE/BLT/BGE/BLTU/BGEU on bypassed rs1/rs2.
- jump_addr = base + imm, with base = PC, or rs1 for JALR. JALR clears bit 0 of the target.
- On branch_taken: the branch moves into EX (JAL/JALR rd write preserved), id_valid clears, and no IF beat is accepted that cycle.
- jump_addr is don't-care when branch_taken=0.

Flush:
- Next edge: id_valid=0 and ex_valid=0, regardless of ex_ready. ex_ctrl=ID_NOP.
- Register-file writes still occur during flush.

Simultaneous events:
- WB write and read of the same register in the same cycle: bypass applies.
- Flush together with load_use or branch: flush wins and branch_taken=0.

Decomposition:
Package riscv_definitions gains:
- idCtrl_t packed struct: alu_op, alu_src1, alu_src2, data_rd_en, data_wr_en, rd_wr_en, uses_rs1, uses_rs2, cond_jump, uncond_jump, base_addr_sel, illegal.
- Constant ID_NOP: ADD, RS1/RS2, all enables 0.

Sub-module id_ctrl_decode:
- Purely combinational: instruction -> idCtrl_t + immediate.
- Reused by future decoders.

The register file and the handshake/hazard logic stay inside id_stage_hs.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with if_valid=1. Expect if_ready=0 and ex_valid=0. After release: if_ready=1 and ex_* all 0.
2. ADDI x1,x0,5 (0x00500093) at pc 0x100. Two edges later: ex_valid=1, ex_imm=5, alu_op=ADD, alu_src2=IMM, ex_rd_addr=1, ex_pc=0x100.
3. Backpressure: stream 4 ADDIs with ex_ready=0 for 3 cycles mid-stream. Expect ex_* stable, if_ready=0 once ID is full, and all 4 emerge in order with no duplicates.
4. Load-use: LW x5,0(x1) then ADD x6,x5,x5. Expect hazard_stall=1 for one cycle and one ex_valid=0 bubble. With WB writing x5=0x1234 in the ADD fire cycle, ex_rs1=ex_rs2=0x1234 (BYPASS_WB=1). With BYPASS_WB=0, the old value is read.
5. Branch: BEQ x0,x0,+16 at 0x200. Expect branch_taken=1 for one cycle, jump_addr=0x210 and if_ready=0 that cycle. JALR x1,7(x2) with x2=0x1000 gives jump_addr=0x1006 and ex_ctrl.rd_wr_en=1.
6. Flush with ex_valid=1, ex_ready=0 and ID full. Next cycle: ex_valid=0, if_ready=1. The opcode 0x0000007F entry shows ex_ctrl.illegal=1 and rd_wr_en=0.

Source files
------------

// File: rtl/riscv_definitions_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU selectors and the ID control word.
package riscv_definitions;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } aluOp_t;

    typedef enum logic [1:0] {SRC1_RS1, SRC1_PC, SRC1_ZERO} aluSrc1_t;
    typedef enum logic [1:0] {SRC2_RS2, SRC2_IMM, SRC2_FOUR} aluSrc2_t;

    // base_addr_sel: 0 = PC-relative target, 1 = rs1-relative (JALR)
    typedef struct packed {
        aluOp_t   alu_op;
        aluSrc1_t alu_src1;
        aluSrc2_t alu_src2;
        logic     data_rd_en;
        logic     data_wr_en;
        logic     rd_wr_en;
        logic     uses_rs1;
        logic     uses_rs2;
        logic     cond_jump;
        logic     uncond_jump;
        logic     base_addr_sel;
        logic     illegal;
    } idCtrl_t;

    localparam idCtrl_t ID_NOP = '{
        alu_op: ALU_ADD, alu_src1: SRC1_RS1, alu_src2: SRC2_RS2,
        data_rd_en: 1'b0, data_wr_en: 1'b0, rd_wr_en: 1'b0,
        uses_rs1: 1'b0, uses_rs2: 1'b0, cond_jump: 1'b0,
        uncond_jump: 1'b0, base_addr_sel: 1'b0, illegal: 1'b0
    };

    // alt is instr[30]; it selects SUB only for register-register ops
    function automatic aluOp_t alu_from_funct3(input logic [2:0] funct3,
                                               input logic alt,
                                               input logic is_reg);
        case (funct3)
            3'b000:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_ctrl_decode.sv
// Combinational RV32I decoder: instruction word to ID control word and sign-extended immediate.
module id_ctrl_decode
    import riscv_definitions::*;
#(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic [31:0] inst,
    output idCtrl_t     ctrl,
    output logic [31:0] imm
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        legal;
    logic        oob;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    function automatic logic reg_oob(input logic [4:0] r);
        return 32'(r) >= NUM_REGS;
    endfunction

    always_comb begin
        ctrl  = ID_NOP;
        imm   = '0;
        legal = 1'b1;
        case (opcode)
            OP_LUI: begin
                ctrl.alu_src1 = SRC1_ZERO;
                ctrl.alu_src2 = SRC2_IMM;
                ctrl.rd_wr_en = 1'b1;
                imm           = imm_u;
            end
            OP_AUIPC: begin
                ctrl.alu_src1 = SRC1_PC;
                ctrl.alu_src2 = SRC2_IMM;
                ctrl.rd_wr_en = 1'b1;
                imm           = imm_u;
            end
            OP_JAL: begin
                ctrl.alu_src1    = SRC1_PC;
                ctrl.alu_src2    = SRC2_FOUR;
                ctrl.rd_wr_en    = 1'b1;
                ctrl.uncond_jump = 1'b1;
                imm              = imm_j;
            end
            OP_JALR: begin
                ctrl.alu_src1      = SRC1_PC;
                ctrl.alu_src2      = SRC2_FOUR;
                ctrl.rd_wr_en      = 1'b1;
                ctrl.uses_rs1      = 1'b1;
                ctrl.uncond_jump   = 1'b1;
                ctrl.base_addr_sel = 1'b1;
                imm                = imm_i;
                legal              = (funct3 == 3'b000);
            end
            OP_BRANCH: begin
                ctrl.alu_op    = ALU_SUB;
                ctrl.uses_rs1  = 1'b1;
                ctrl.uses_rs2  = 1'b1;
                ctrl.cond_jump = 1'b1;
                imm            = imm_b;
                legal          = (funct3[2:1] != 2'b01);
            end
            OP_LOAD: begin
                ctrl.alu_src2   = SRC2_IMM;
                ctrl.data_rd_en = 1'b1;
                ctrl.rd_wr_en   = 1'b1;
                ctrl.uses_rs1   = 1'b1;
                imm             = imm_i;
                legal           = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
            end
            OP_STORE: begin
                ctrl.alu_src2   = SRC2_IMM;
                ctrl.data_wr_en = 1'b1;
                ctrl.uses_rs1   = 1'b1;
                ctrl.uses_rs2   = 1'b1;
                imm             = imm_s;
                legal           = !funct3[2] && (funct3 != 3'b011);
            end
            OP_IMM: begin
                ctrl.alu_op   = alu_from_funct3(funct3, inst[30], 1'b0);
                ctrl.alu_src2 = SRC2_IMM;
                ctrl.rd_wr_en = 1'b1;
                ctrl.uses_rs1 = 1'b1;
                imm           = imm_i;
            end
            OP_REG: begin
                ctrl.alu_op   = alu_from_funct3(funct3, inst[30], 1'b1);
                ctrl.rd_wr_en = 1'b1;
                ctrl.uses_rs1 = 1'b1;
                ctrl.uses_rs2 = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: ;
            default: legal = 1'b0;
        endcase

        // RV32E-style configurations reject register fields beyond the file
        oob = (ctrl.rd_wr_en && reg_oob(inst[11:7])) ||
              (ctrl.uses_rs1 && reg_oob(inst[19:15])) ||
              (ctrl.uses_rs2 && reg_oob(inst[24:20]));

        if (!legal || oob) begin
            ctrl         = ID_NOP;
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/id_stage_hs.sv
// Handshaked instruction-decode stage: ID holding register, register file with WB bypass,
// load-use interlock, jump/branch resolution and a stallable ID/EX register.
module id_stage_hs
    import riscv_definitions::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter bit          BYPASS_WB = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clk_en,
    input  logic                        if_valid,
    output logic                        if_ready,
    input  logic [31:0]                 if_inst,
    input  logic [XLEN-1:0]             if_pc,
    input  logic                        wb_wr_en,
    input  logic [$clog2(NUM_REGS)-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]             wb_data,
    input  logic                        flush,
    output logic                        ex_valid,
    input  logic                        ex_ready,
    output idCtrl_t                     ex_ctrl,
    output logic [XLEN-1:0]             ex_pc,
    output logic [XLEN-1:0]             ex_rs1,
    output logic [XLEN-1:0]             ex_rs2,
    output logic [XLEN-1:0]             ex_imm,
    output logic [$clog2(NUM_REGS)-1:0] ex_rd_addr,
    output logic [$clog2(NUM_REGS)-1:0] ex_rs1_addr,
    output logic [$clog2(NUM_REGS)-1:0] ex_rs2_addr,
    output logic [2:0]                  ex_funct3,
    output logic                        branch_taken,
    output logic [XLEN-1:0]             jump_addr,
    output logic                        hazard_stall
);

    localparam int unsigned AW = $clog2(NUM_REGS);

    logic            id_valid;
    logic [31:0]     id_inst;
    logic [XLEN-1:0] id_pc;
    idCtrl_t         dec_ctrl;
    logic [31:0]     dec_imm;
    logic [AW-1:0]   rs1_addr, rs2_addr, rd_addr;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [XLEN-1:0] rf [NUM_REGS];
    logic            active, load_use, ex_free, id_fire, take_jump, cond_true;
    logic [XLEN-1:0] target;

    id_ctrl_decode #(.NUM_REGS(NUM_REGS)) u_decode (
        .inst (id_inst),
        .ctrl (dec_ctrl),
        .imm  (dec_imm)
    );

    assign rs1_addr = id_inst[15 +: AW];
    assign rs2_addr = id_inst[20 +: AW];
    assign rd_addr  = id_inst[7 +: AW];

    always_comb begin
        rs1_data = rf[rs1_addr];
        rs2_data = rf[rs2_addr];
        if (BYPASS_WB && wb_wr_en && wb_rd_addr != '0) begin
            if (wb_rd_addr == rs1_addr) rs1_data = wb_data;
            if (wb_rd_addr == rs2_addr) rs2_data = wb_data;
        end
        if (rs1_addr == '0) rs1_data = '0;
        if (rs2_addr == '0) rs2_data = '0;
    end

    always_comb begin
        case (id_inst[14:12])
            3'b000:  cond_true = (rs1_data == rs2_data);
            3'b001:  cond_true = (rs1_data != rs2_data);
            3'b100:  cond_true = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  cond_true = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  cond_true = (rs1_data <  rs2_data);
            3'b111:  cond_true = (rs1_data >= rs2_data);
            default: cond_true = 1'b0;
        endcase
    end

    assign active    = rst_n && clk_en;
    assign load_use  = id_valid && ex_valid && ex_ctrl.data_rd_en && ex_rd_addr != '0 &&
                       ((dec_ctrl.uses_rs1 && ex_rd_addr == rs1_addr) ||
                        (dec_ctrl.uses_rs2 && ex_rd_addr == rs2_addr));
    assign ex_free   = !ex_valid || ex_ready;
    assign id_fire   = id_valid && ex_free && !load_use && !flush;
    assign take_jump = dec_ctrl.uncond_jump || (dec_ctrl.cond_jump && cond_true);

    assign branch_taken = active && id_fire && take_jump;
    assign hazard_stall = active && load_use && ex_free;
    assign if_ready     = active && (!id_valid || id_fire) && !(id_fire && take_jump) && !flush;

    assign target    = (dec_ctrl.base_addr_sel ? rs1_data : id_pc) + dec_imm;
    assign jump_addr = {target[XLEN-1:1], target[0] && !dec_ctrl.base_addr_sel};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (clk_en && wb_wr_en && wb_rd_addr != '0) begin
            rf[wb_rd_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            id_inst  <= '0;
            id_pc    <= '0;
        end else if (clk_en) begin
            if (flush) begin
                id_valid <= 1'b0;
            end else if (if_valid && if_ready) begin
                id_valid <= 1'b1;
                id_inst  <= if_inst;
                id_pc    <= if_pc;
            end else if (id_fire) begin
                id_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= ID_NOP;
            ex_pc       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_imm      <= '0;
            ex_rd_addr  <= '0;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
            ex_funct3   <= '0;
        end else if (clk_en) begin
            if (flush) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= ID_NOP;
            end else if (id_fire) begin
                ex_valid    <= 1'b1;
                ex_ctrl     <= dec_ctrl;
                ex_pc       <= id_pc;
                ex_rs1      <= rs1_data;
                ex_rs2      <= rs2_data;
                ex_imm      <= dec_imm;
                ex_rd_addr  <= rd_addr;
                ex_rs1_addr <= rs1_addr;
                ex_rs2_addr <= rs2_addr;
                ex_funct3   <= id_inst[14:12];
            end else if (ex_ready && ex_valid) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_hs.sv
// Scoreboard bench for id_stage_hs; a second instance without WB bypass covers the stale-read case.
module tb_id_stage_hs;
    import riscv_definitions::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, clk_en, if_valid, wb_wr_en, flush, ex_ready;
    logic [31:0] if_inst, if_pc, wb_data;
    logic [4:0]  wb_rd_addr;

    logic        if_ready, ex_valid, branch_taken, hazard_stall;
    idCtrl_t     ex_ctrl;
    logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm, jump_addr;
    logic [4:0]  ex_rd_addr, ex_rs1_addr, ex_rs2_addr;
    logic [2:0]  ex_funct3;

    logic        nb_if_ready, nb_ex_valid, nb_branch_taken, nb_hazard_stall;
    idCtrl_t     nb_ex_ctrl;
    logic [31:0] nb_ex_pc, nb_ex_rs1, nb_ex_rs2, nb_ex_imm, nb_jump_addr;
    logic [4:0]  nb_ex_rd_addr, nb_ex_rs1_addr, nb_ex_rs2_addr;
    logic [2:0]  nb_ex_funct3;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] model_rf [32];

    always #5 clk = ~clk;

    id_stage_hs #(.XLEN(32), .NUM_REGS(32), .BYPASS_WB(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
        .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm), .ex_rd_addr(ex_rd_addr),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_funct3(ex_funct3),
        .branch_taken(branch_taken), .jump_addr(jump_addr), .hazard_stall(hazard_stall)
    );

    id_stage_hs #(.XLEN(32), .NUM_REGS(32), .BYPASS_WB(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .if_valid(if_valid), .if_ready(nb_if_ready), .if_inst(if_inst), .if_pc(if_pc),
        .wb_wr_en(wb_wr_en), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .flush(flush),
        .ex_valid(nb_ex_valid), .ex_ready(ex_ready), .ex_ctrl(nb_ex_ctrl), .ex_pc(nb_ex_pc),
        .ex_rs1(nb_ex_rs1), .ex_rs2(nb_ex_rs2), .ex_imm(nb_ex_imm), .ex_rd_addr(nb_ex_rd_addr),
        .ex_rs1_addr(nb_ex_rs1_addr), .ex_rs2_addr(nb_ex_rs2_addr), .ex_funct3(nb_ex_funct3),
        .branch_taken(nb_branch_taken), .jump_addr(nb_jump_addr), .hazard_stall(nb_hazard_stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] imm,
                                input logic [4:0] rd, input logic [31:0] rs1,
                                input logic [31:0] rs2);
        return '{pc: pc, imm: imm, rd: rd, rs1: rs1, rs2: rs2};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    // Holds the beat until the stage accepts it, then drops if_valid
    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        int n = 0;
        if_valid = 1'b1;
        if_inst  = inst;
        if_pc    = pc;
        #1;
        while (!if_ready && n < 20) begin
            tick();
            n++;
        end
        check("issue_ready", 32'(if_ready), 32'd1);
        tick();
        if_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_wr_en   = 1'b1;
        wb_rd_addr = a;
        wb_data    = d;
        tick();
        wb_wr_en = 1'b0;
        if (a != 5'd0) model_rf[a] = d;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        check("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && clk_en && ex_valid && ex_ready) begin
            if (sb.size() == 0) begin
                check("sb_extra_entry", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("sb_pc",  ex_pc,             mon_e.pc);
                check("sb_imm", ex_imm,            mon_e.imm);
                check("sb_rd",  32'(ex_rd_addr),   32'(mon_e.rd));
                check("sb_rs1", ex_rs1,            mon_e.rs1);
                check("sb_rs2", ex_rs2,            mon_e.rs2);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        rst_n = 1'b0; clk_en = 1'b1; if_valid = 1'b1; if_inst = 32'h0050_0093; if_pc = '0;
        wb_wr_en = 1'b0; wb_rd_addr = '0; wb_data = '0; flush = 1'b0; ex_ready = 1'b1;

        // 1. reset
        tick(); tick();
        check("rst_if_ready", 32'(if_ready), 32'd0);
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        rst_n = 1'b1; if_valid = 1'b0;
        #1;
        check("post_rst_if_ready", 32'(if_ready), 32'd1);
        check("post_rst_ex_ctrl", 32'(ex_ctrl), 32'(ID_NOP));
        check("post_rst_ex_pc", ex_pc, 32'd0);
        check("post_rst_ex_imm", ex_imm, 32'd0);
        check("post_rst_ex_rd", 32'(ex_rd_addr), 32'd0);

        // 2. single ADDI x1,x0,5
        sb.push_back(mk(32'h100, 32'd5, 5'd1, 32'd0, model_rf[5]));
        issue(32'h0050_0093, 32'h100);
        tick();
        check("addi_ex_valid", 32'(ex_valid), 32'd1);
        check("addi_ex_imm", ex_imm, 32'd5);
        check("addi_alu_op", 32'(ex_ctrl.alu_op), 32'(ALU_ADD));
        check("addi_alu_src2", 32'(ex_ctrl.alu_src2), 32'(SRC2_IMM));
        check("addi_ex_rd", 32'(ex_rd_addr), 32'd1);
        check("addi_ex_pc", ex_pc, 32'h100);
        drain();

        // 3. backpressure mid-stream
        for (int i = 0; i < 4; i++)
            sb.push_back(mk(32'h300 + 32'(4 * i), 32'(i + 1), 5'(10 + i), 32'd0, model_rf[i + 1]));
        issue(addi(5'd10, 5'd0, 12'd1), 32'h300);
        issue(addi(5'd11, 5'd0, 12'd2), 32'h304);
        ex_ready = 1'b0;
        #1;
        check("bp_if_ready_full", 32'(if_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_ex_pc_hold", ex_pc, 32'h300);
            check("bp_ex_valid_hold", 32'(ex_valid), 32'd1);
            check("bp_if_ready_hold", 32'(if_ready), 32'd0);
        end
        ex_ready = 1'b1;
        issue(addi(5'd12, 5'd0, 12'd3), 32'h308);
        issue(addi(5'd13, 5'd0, 12'd4), 32'h30C);
        drain();

        // 4. load-use interlock with WB bypass in the fire cycle
        wb_write(5'd1, 32'h40);
        wb_write(5'd5, 32'h55);
        sb.push_back(mk(32'h500, 32'd0, 5'd5, 32'h40, 32'd0));
        issue(32'h0000_A283, 32'h500);
        sb.push_back(mk(32'h504, 32'd0, 5'd6, 32'h1234, 32'h1234));
        issue(32'h0052_8333, 32'h504);
        #1;
        check("lu_hazard_stall", 32'(hazard_stall), 32'd1);
        check("lu_if_ready", 32'(if_ready), 32'd0);
        tick();
        check("lu_bubble", 32'(ex_valid), 32'd0);
        check("lu_stall_once", 32'(hazard_stall), 32'd0);
        wb_wr_en = 1'b1; wb_rd_addr = 5'd5; wb_data = 32'h1234;
        tick();
        wb_wr_en = 1'b0;
        model_rf[5] = 32'h1234;
        check("lu_rs1_addr", 32'(ex_rs1_addr), 32'd5);
        check("lu_rs2_addr", 32'(ex_rs2_addr), 32'd5);
        check("nobyp_ex_valid", 32'(nb_ex_valid), 32'd1);
        check("nobyp_rs1_old", nb_ex_rs1, 32'h55);
        check("nobyp_rs2_old", nb_ex_rs2, 32'h55);
        drain();

        // 5. BEQ, first held off by clk_en=0, then JALR
        sb.push_back(mk(32'h200, 32'd16, 5'd16, 32'd0, 32'd0));
        issue(32'h0000_0863, 32'h200);
        clk_en = 1'b0;
        #1;
        check("clken_branch_off", 32'(branch_taken), 32'd0);
        check("clken_if_ready_off", 32'(if_ready), 32'd0);
        tick();
        clk_en = 1'b1;
        if_valid = 1'b1; if_inst = addi(5'd3, 5'd0, 12'd9); if_pc = 32'h204;
        #1;
        check("beq_taken", 32'(branch_taken), 32'd1);
        check("beq_target", jump_addr, 32'h210);
        check("beq_if_ready", 32'(if_ready), 32'd0);
        tick();
        if_valid = 1'b0;
        check("beq_taken_once", 32'(branch_taken), 32'd0);
        drain();
        wb_write(5'd2, 32'h1000);
        sb.push_back(mk(32'h240, 32'd7, 5'd1, 32'h1000, model_rf[7]));
        issue(32'h0071_00E7, 32'h240);
        #1;
        check("jalr_taken", 32'(branch_taken), 32'd1);
        check("jalr_target", jump_addr, 32'h1006);
        tick();
        check("jalr_rd_wr_en", 32'(ex_ctrl.rd_wr_en), 32'd1);
        check("jalr_uncond", 32'(ex_ctrl.uncond_jump), 32'd1);
        drain();

        // 6. flush with EX stalled and ID full; EX holds an illegal opcode
        issue(32'h0000_007F, 32'h400);
        issue(addi(5'd20, 5'd0, 12'd3), 32'h404);
        ex_ready = 1'b0;
        #1;
        check("ill_ex_valid", 32'(ex_valid), 32'd1);
        check("ill_flag", 32'(ex_ctrl.illegal), 32'd1);
        check("ill_rd_wr_en", 32'(ex_ctrl.rd_wr_en), 32'd0);
        flush = 1'b1;
        #1;
        check("flush_if_ready", 32'(if_ready), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_ex_valid", 32'(ex_valid), 32'd0);
        check("flush_if_ready_after", 32'(if_ready), 32'd1);
        check("flush_ex_ctrl", 32'(ex_ctrl), 32'(ID_NOP));

        // flush beats a pending branch
        ex_ready = 1'b1;
        issue(32'h0000_0863, 32'h600);
        flush = 1'b1;
        #1;
        check("flush_kills_branch", 32'(branch_taken), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_branch_ex_valid", 32'(ex_valid), 32'd0);
        tick(); tick();
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
